// File: rtl/regfile_pkg.sv
// Purpose: shared widths, the writeback request record and a one-hot decode helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package regfile_pkg;

  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 5;
  localparam int ZERO_REG = 31;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] rw;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  // One-hot decode of a register index into the 32-bit scoreboard view.
  function automatic logic [31:0] oneHot(input logic [ADDR_W-1:0] idx);
    return 32'd1 << idx;
  endfunction

endpackage

// File: rtl/wb_slot.sv
// Purpose: one-entry writeback holding slot; drops zero-register writes on acceptance.
// Latency: accepted request is visible in the slot one cycle after the accepting edge.
// Backpressure: ready while empty or while being drained this cycle (back-to-back refill).
module wb_slot
  import regfile_pkg::*;
(
  input  logic    Clk,
  input  logic    Reset,
  input  wb_req_t inReq,
  output logic    inReady,
  input  logic    grant,
  output wb_req_t slot,
  output logic    load
);

  assign inReady = !Reset && (!slot.valid || grant);

  // Writes to the zero register are acknowledged but never stored.
  assign load = inReq.valid && inReady && (inReq.rw != ADDR_W'(ZERO_REG));

  // Slot contents: refill wins over drain so a granted slot can accept in the same edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      slot <= '0;
    end else if (load) begin
      slot.valid <= 1'b1;
      slot.rw    <= inReq.rw;
      slot.data  <= inReq.data;
    end else if (grant) begin
      slot.valid <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Purpose: shares the register file write port between ALU and load writeback slots.
// Latency: uncontested request accepted at edge N drives RegWr/RW/BusW from edge N+1 for one cycle.
// Backpressure: a slot's ready drops while it holds an entry that is not granted this cycle.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int MAX_WAIT = 3
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              AluValid,
  output logic              AluReady,
  input  logic [ADDR_W-1:0] AluRW,
  input  logic [DATA_W-1:0] AluBusW,
  input  logic              MemValid,
  output logic              MemReady,
  input  logic [ADDR_W-1:0] MemRW,
  input  logic [DATA_W-1:0] MemBusW,
  output logic              RegWr,
  output logic [ADDR_W-1:0] RW,
  output logic [DATA_W-1:0] BusW,
  output logic [31:0]       Pending
);

  localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

  wb_req_t           aluIn, memIn;
  wb_req_t           aluSlot, memSlot;
  logic              aluLoad, memLoad;
  logic              aluGrant, memGrant;
  logic [WAIT_W-1:0] aluWait;
  logic              olderIsAlu;

  assign aluIn.valid = AluValid;
  assign aluIn.rw    = AluRW;
  assign aluIn.data  = AluBusW;
  assign memIn.valid = MemValid;
  assign memIn.rw    = MemRW;
  assign memIn.data  = MemBusW;

  wb_slot uAluSlot (
    .Clk     (Clk),
    .Reset   (Reset),
    .inReq   (aluIn),
    .inReady (AluReady),
    .grant   (aluGrant),
    .slot    (aluSlot),
    .load    (aluLoad)
  );

  wb_slot uMemSlot (
    .Clk     (Clk),
    .Reset   (Reset),
    .inReq   (memIn),
    .inReady (MemReady),
    .grant   (memGrant),
    .slot    (memSlot),
    .load    (memLoad)
  );

  // Grant: same-register ordering first, then the starvation override, then Mem priority.
  always_comb begin
    aluGrant = 1'b0;
    memGrant = 1'b0;
    if (aluSlot.valid && memSlot.valid) begin
      if (aluSlot.rw == memSlot.rw) begin
        aluGrant = olderIsAlu;
        memGrant = !olderIsAlu;
      end else if (aluWait == WAIT_W'(MAX_WAIT)) begin
        aluGrant = 1'b1;
      end else begin
        memGrant = 1'b1;
      end
    end else if (memSlot.valid) begin
      memGrant = 1'b1;
    end else if (aluSlot.valid) begin
      aluGrant = 1'b1;
    end
  end

  // Starvation counter: counts ALU losses, saturating; any ALU grant or empty slot clears it.
  always_ff @(posedge Clk) begin
    if (Reset || !aluSlot.valid || aluGrant) begin
      aluWait <= '0;
    end else if (aluWait != WAIT_W'(MAX_WAIT)) begin
      aluWait <= aluWait + WAIT_W'(1);
    end
  end

  // Age flag: a filling slot is older only if the other slot will not still hold an entry
  // afterwards; a simultaneous fill of both counts Mem as older.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      olderIsAlu <= 1'b0;
    end else if (aluLoad && memLoad) begin
      olderIsAlu <= 1'b0;
    end else if (aluLoad) begin
      olderIsAlu <= !(memSlot.valid && !memGrant);
    end else if (memLoad) begin
      olderIsAlu <= aluSlot.valid && !aluGrant;
    end
  end

  // Output register: one write pulse per grant; index and data hold while idle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      RegWr <= 1'b0;
      RW    <= ADDR_W'(ZERO_REG);
      BusW  <= '0;
    end else if (aluGrant) begin
      RegWr <= 1'b1;
      RW    <= aluSlot.rw;
      BusW  <= aluSlot.data;
    end else if (memGrant) begin
      RegWr <= 1'b1;
      RW    <= memSlot.rw;
      BusW  <= memSlot.data;
    end else begin
      RegWr <= 1'b0;
    end
  end

  // Scoreboard: every register with a write still queued or on the port.
  always_comb begin
    Pending = '0;
    if (aluSlot.valid) Pending = Pending | oneHot(aluSlot.rw);
    if (memSlot.valid) Pending = Pending | oneHot(memSlot.rw);
    if (RegWr)         Pending = Pending | oneHot(RW);
    Pending[ZERO_REG] = 1'b0;
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Purpose: directed self-checking bench for the writeback arbiter.
// Latency: inputs driven 2 time units after posedge, outputs observed at the same point.
// Backpressure: stimulus only advances a request once Valid&&Ready was seen before the edge.
module tb_regfile_wb_arbiter;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        AluValid, AluReady, MemValid, MemReady;
  logic [4:0]  AluRW, MemRW, RW;
  logic [63:0] AluBusW, MemBusW, BusW;
  logic        RegWr;
  logic [31:0] Pending;

  int compared   = 0;
  int mismatched = 0;

  logic [63:0] shadow [32];

  regfile_wb_arbiter dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .AluValid (AluValid),
    .AluReady (AluReady),
    .AluRW    (AluRW),
    .AluBusW  (AluBusW),
    .MemValid (MemValid),
    .MemReady (MemReady),
    .MemRW    (MemRW),
    .MemBusW  (MemBusW),
    .RegWr    (RegWr),
    .RW       (RW),
    .BusW     (BusW),
    .Pending  (Pending)
  );

  always #5 Clk = ~Clk;

  // Register file model: captures on the negedge inside the RegWr cycle.
  always @(negedge Clk) begin
    if (RegWr) shadow[RW] = BusW;
  end

  task automatic step();
    @(posedge Clk);
    #2;
  endtask

  task automatic idle();
    AluValid = 1'b0;
    MemValid = 1'b0;
    AluRW    = '0;
    MemRW    = '0;
    AluBusW  = '0;
    MemBusW  = '0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    idle();
    for (int i = 0; i < 32; i++) shadow[i] = '0;
    step();
    step();
    compared++; if (RegWr !== 1'b0) begin mismatched++; $display("FAIL rst_regwr: got %0b want 0", RegWr); end
    compared++; if (RW !== 5'd31) begin mismatched++; $display("FAIL rst_rw: got %0d want 31", RW); end
    compared++; if (BusW !== 64'd0) begin mismatched++; $display("FAIL rst_busw: got %0h want 0", BusW); end
    compared++; if (Pending !== 32'd0) begin mismatched++; $display("FAIL rst_pending: got %0h want 0", Pending); end
    compared++; if (AluReady !== 1'b0) begin mismatched++; $display("FAIL rst_aluready: got %0b want 0", AluReady); end
    compared++; if (MemReady !== 1'b0) begin mismatched++; $display("FAIL rst_memready: got %0b want 0", MemReady); end
    Reset = 1'b0;
    #1;
    compared++; if (AluReady !== 1'b1) begin mismatched++; $display("FAIL rst_aluready_after: got %0b want 1", AluReady); end
    compared++; if (MemReady !== 1'b1) begin mismatched++; $display("FAIL rst_memready_after: got %0b want 1", MemReady); end
  endtask

  task automatic test_single();
    AluValid = 1'b1; AluRW = 5'd3; AluBusW = 64'hA5;
    #1;
    compared++; if (AluReady !== 1'b1) begin mismatched++; $display("FAIL single_ready: got %0b want 1", AluReady); end
    step();
    AluValid = 1'b0;
    compared++; if (RegWr !== 1'b0) begin mismatched++; $display("FAIL single_early: got %0b want 0", RegWr); end
    compared++; if (Pending !== 32'h8) begin mismatched++; $display("FAIL single_pend1: got %0h want 8", Pending); end
    step();
    compared++; if (RegWr !== 1'b1) begin mismatched++; $display("FAIL single_regwr: got %0b want 1", RegWr); end
    compared++; if (RW !== 5'd3) begin mismatched++; $display("FAIL single_rw: got %0d want 3", RW); end
    compared++; if (BusW !== 64'hA5) begin mismatched++; $display("FAIL single_busw: got %0h want a5", BusW); end
    compared++; if (Pending !== 32'h8) begin mismatched++; $display("FAIL single_pend2: got %0h want 8", Pending); end
    step();
    compared++; if (RegWr !== 1'b0) begin mismatched++; $display("FAIL single_pulse: got %0b want 0", RegWr); end
    compared++; if (Pending !== 32'h0) begin mismatched++; $display("FAIL single_pend3: got %0h want 0", Pending); end
    compared++; if (RW !== 5'd3) begin mismatched++; $display("FAIL single_hold: got %0d want 3", RW); end
  endtask

  task automatic test_same_edge();
    AluValid = 1'b1; AluRW = 5'd1; AluBusW = 64'h101;
    MemValid = 1'b1; MemRW = 5'd2; MemBusW = 64'h202;
    step();
    idle();
    compared++; if (AluReady !== 1'b0) begin mismatched++; $display("FAIL same_aluready_lose: got %0b want 0", AluReady); end
    compared++; if (MemReady !== 1'b1) begin mismatched++; $display("FAIL same_memready: got %0b want 1", MemReady); end
    compared++; if (Pending !== 32'h6) begin mismatched++; $display("FAIL same_pend: got %0h want 6", Pending); end
    step();
    compared++; if ({RegWr, RW, BusW} !== {1'b1, 5'd2, 64'h202}) begin mismatched++; $display("FAIL same_first: got %0b/%0d/%0h want 1/2/202", RegWr, RW, BusW); end
    compared++; if (AluReady !== 1'b1) begin mismatched++; $display("FAIL same_aluready_drain: got %0b want 1", AluReady); end
    step();
    compared++; if ({RegWr, RW, BusW} !== {1'b1, 5'd1, 64'h101}) begin mismatched++; $display("FAIL same_second: got %0b/%0d/%0h want 1/1/101", RegWr, RW, BusW); end
    compared++; if (Pending !== 32'h2) begin mismatched++; $display("FAIL same_pend2: got %0h want 2", Pending); end
    step();
    compared++; if (RegWr !== 1'b0) begin mismatched++; $display("FAIL same_idle: got %0b want 0", RegWr); end
  endtask

  task automatic test_starvation();
    logic [4:0]  obsRw[$];
    logic [63:0] obsDat[$];
    logic [4:0]  expRw[7];
    logic [63:0] expDat[7];
    logic        aluAcc, memAcc;
    int          mi;
    expRw  = '{5'd10, 5'd11, 5'd12, 5'd7, 5'd13, 5'd14, 5'd15};
    expDat = '{64'h1000, 64'h1001, 64'h1002, 64'h77, 64'h1003, 64'h1004, 64'h1005};
    mi = 0;
    AluValid = 1'b1; AluRW = 5'd7;  AluBusW = 64'h77;
    MemValid = 1'b1; MemRW = 5'd10; MemBusW = 64'h1000;
    for (int cyc = 0; cyc < 14; cyc++) begin
      aluAcc = AluValid && AluReady;
      memAcc = MemValid && MemReady;
      step();
      if (RegWr) begin obsRw.push_back(RW); obsDat.push_back(BusW); end
      if (aluAcc) AluValid = 1'b0;
      if (memAcc) begin
        mi++;
        if (mi < 6) begin
          MemRW = 5'(10 + mi); MemBusW = 64'h1000 + 64'(mi);
        end else begin
          MemValid = 1'b0;
        end
      end
    end
    idle();
    compared++; if (obsRw.size() !== 7) begin mismatched++; $display("FAIL starve_count: got %0d want 7", obsRw.size()); end
    for (int i = 0; i < 7; i++) begin
      if (i < obsRw.size()) begin
        compared++; if (obsRw[i] !== expRw[i]) begin mismatched++; $display("FAIL starve_rw[%0d]: got %0d want %0d", i, obsRw[i], expRw[i]); end
        compared++; if (obsDat[i] !== expDat[i]) begin mismatched++; $display("FAIL starve_dat[%0d]: got %0h want %0h", i, obsDat[i], expDat[i]); end
      end
    end
  endtask

  task automatic test_same_reg();
    // ALU accepted first, load to the same register one cycle later.
    AluValid = 1'b1; AluRW = 5'd5; AluBusW = 64'h11;
    step();
    AluValid = 1'b0;
    MemValid = 1'b1; MemRW = 5'd5; MemBusW = 64'h22;
    step();
    MemValid = 1'b0;
    compared++; if ({RegWr, RW, BusW} !== {1'b1, 5'd5, 64'h11}) begin mismatched++; $display("FAIL order_first: got %0b/%0d/%0h want 1/5/11", RegWr, RW, BusW); end
    step();
    compared++; if ({RegWr, RW, BusW} !== {1'b1, 5'd5, 64'h22}) begin mismatched++; $display("FAIL order_second: got %0b/%0d/%0h want 1/5/22", RegWr, RW, BusW); end
    step();
    compared++; if (shadow[5] !== 64'h22) begin mismatched++; $display("FAIL order_r5: got %0h want 22", shadow[5]); end
    // ALU blocked behind a load, then a newer load to the ALU's register: ALU must still go first.
    AluValid = 1'b1; AluRW = 5'd6;  AluBusW = 64'h66;
    MemValid = 1'b1; MemRW = 5'd20; MemBusW = 64'hA0;
    step();
    AluValid = 1'b0;
    MemRW = 5'd6; MemBusW = 64'hB6;
    compared++; if (MemReady !== 1'b1) begin mismatched++; $display("FAIL order_memready: got %0b want 1", MemReady); end
    step();
    MemValid = 1'b0;
    compared++; if ({RegWr, RW, BusW} !== {1'b1, 5'd20, 64'hA0}) begin mismatched++; $display("FAIL order_w1: got %0b/%0d/%0h want 1/20/a0", RegWr, RW, BusW); end
    step();
    compared++; if ({RegWr, RW, BusW} !== {1'b1, 5'd6, 64'h66}) begin mismatched++; $display("FAIL order_w2: got %0b/%0d/%0h want 1/6/66", RegWr, RW, BusW); end
    step();
    compared++; if ({RegWr, RW, BusW} !== {1'b1, 5'd6, 64'hB6}) begin mismatched++; $display("FAIL order_w3: got %0b/%0d/%0h want 1/6/b6", RegWr, RW, BusW); end
    step();
    compared++; if (shadow[6] !== 64'hB6) begin mismatched++; $display("FAIL order_r6: got %0h want b6", shadow[6]); end
    idle();
  endtask

  task automatic test_zero_reg();
    int pulses;
    pulses = 0;
    AluValid = 1'b1; AluRW = 5'd31; AluBusW = 64'hFF;
    #1;
    compared++; if (AluReady !== 1'b1) begin mismatched++; $display("FAIL zero_ready: got %0b want 1", AluReady); end
    step();
    AluValid = 1'b0;
    compared++; if (AluReady !== 1'b1) begin mismatched++; $display("FAIL zero_ready_after: got %0b want 1", AluReady); end
    compared++; if (Pending !== 32'h0) begin mismatched++; $display("FAIL zero_pend: got %0h want 0", Pending); end
    for (int i = 0; i < 3; i++) begin
      step();
      if (RegWr) pulses++;
    end
    compared++; if (pulses !== 0) begin mismatched++; $display("FAIL zero_pulses: got %0d want 0", pulses); end
  endtask

  task automatic test_reset_mid();
    int pulses;
    pulses = 0;
    AluValid = 1'b1; AluRW = 5'd12; AluBusW = 64'hC;
    MemValid = 1'b1; MemRW = 5'd13; MemBusW = 64'hD;
    step();
    idle();
    compared++; if (Pending !== 32'h3000) begin mismatched++; $display("FAIL rmid_pend_full: got %0h want 3000", Pending); end
    Reset = 1'b1;
    #1;
    compared++; if (AluReady !== 1'b0) begin mismatched++; $display("FAIL rmid_aluready: got %0b want 0", AluReady); end
    compared++; if (MemReady !== 1'b0) begin mismatched++; $display("FAIL rmid_memready: got %0b want 0", MemReady); end
    step();
    if (RegWr) pulses++;
    Reset = 1'b0;
    #1;
    compared++; if (AluReady !== 1'b1) begin mismatched++; $display("FAIL rmid_aluready_after: got %0b want 1", AluReady); end
    compared++; if (MemReady !== 1'b1) begin mismatched++; $display("FAIL rmid_memready_after: got %0b want 1", MemReady); end
    compared++; if (Pending !== 32'h0) begin mismatched++; $display("FAIL rmid_pend: got %0h want 0", Pending); end
    for (int i = 0; i < 3; i++) begin
      step();
      if (RegWr) pulses++;
    end
    compared++; if (pulses !== 0) begin mismatched++; $display("FAIL rmid_pulses: got %0d want 0", pulses); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_same_edge();
    test_starvation();
    test_same_reg();
    test_zero_reg();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
